// File: rtl/spi_sub_oversampled_if.sv
// Bus bundle for spi_sub_oversampled: SPI pins, TX/RX handshakes and status.
// The slave modport is the sub's view; master is the board/user side.
interface spi_sub_oversampled_if #(
  parameter int WORD_SIZE = 8
);
  logic                 sclk;
  logic                 ssn;
  logic                 mosi;
  logic                 miso;
  logic                 miso_oe;
  logic [WORD_SIZE-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [WORD_SIZE-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 active;
  logic                 status_clr;
  logic                 rx_overflow;
  logic                 tx_underflow;
  logic [15:0]          word_count;

  modport slave (
    input  sclk, ssn, mosi, tx_data, tx_valid, rx_ready, status_clr,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, active,
           rx_overflow, tx_underflow, word_count
  );

  modport master (
    output sclk, ssn, mosi, tx_data, tx_valid, rx_ready, status_clr,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, active,
           rx_overflow, tx_underflow, word_count
  );
endinterface

// File: rtl/spi_sub_oversampled.sv
// SPI sub that oversamples sclk/ssn/mosi in sys_clk, with RX/TX FIFOs,
// sticky overflow/underflow flags and a per-transaction word counter.
module spi_sub_oversampled #(
  parameter int                   WORD_SIZE = 8,
  parameter int                   RX_DEPTH  = 8,
  parameter int                   TX_DEPTH  = 8,
  parameter bit                   CPOL      = 1'b0,
  parameter bit                   CPHA      = 1'b0,
  parameter bit                   MSB_FIRST = 1'b1,
  parameter logic [WORD_SIZE-1:0] IDLE_WORD = '0
) (
  input logic                  sys_clk,
  input logic                  sys_rst,
  spi_sub_oversampled_if.slave bus
);
  localparam int BW      = $clog2(WORD_SIZE);
  localparam int RAW     = $clog2(RX_DEPTH);
  localparam int TAW     = $clog2(TX_DEPTH);
  localparam int OUT_BIT = MSB_FIRST ? WORD_SIZE - 1 : 0;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_SIZE - 1);
  localparam logic [RAW:0]  RX_FULL  = (RAW+1)'(RX_DEPTH);
  localparam logic [TAW:0]  TX_FULL  = (TAW+1)'(TX_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_next;
  logic [2:0]           sclk_sync, ssn_sync;
  logic [1:0]           mosi_sync;
  logic [BW-1:0]        bit_cnt;
  logic                 loaded;
  logic [15:0]          word_count;
  logic [WORD_SIZE-1:0] tx_shreg, rx_shreg, rx_next;
  logic [WORD_SIZE-1:0] tx_mem [TX_DEPTH];
  logic [WORD_SIZE-1:0] rx_mem [RX_DEPTH];
  logic [TAW-1:0]       tx_wr, tx_rd;
  logic [RAW-1:0]       rx_wr, rx_rd;
  logic [TAW:0]         tx_cnt;
  logic [RAW:0]         rx_cnt;
  logic                 rx_overflow, tx_underflow;
  logic                 start, load_tx, shift_tx, sample, word_done;

  // ssn sync resets to "asserted" so a transfer already running at reset release never shows a falling edge
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sclk_sync <= {3{CPOL}};
      ssn_sync  <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], bus.sclk};
      ssn_sync  <= {ssn_sync[1:0], bus.ssn};
      mosi_sync <= {mosi_sync[0], bus.mosi};
    end
  end

  logic sclk_edge, leading_edge, trailing_edge, sample_edge, drive_edge;
  logic ssn_fall, ssn_rise;
  assign sclk_edge     = sclk_sync[2] != sclk_sync[1];
  assign leading_edge  = sclk_edge && (sclk_sync[2] == CPOL);
  assign trailing_edge = sclk_edge && (sclk_sync[2] != CPOL);
  assign sample_edge   = CPHA ? trailing_edge : leading_edge;
  assign drive_edge    = CPHA ? leading_edge : trailing_edge;
  assign ssn_fall      = ssn_sync[2] && !ssn_sync[1];
  assign ssn_rise      = !ssn_sync[2] && ssn_sync[1];

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (ssn_fall) begin
          state_next = SHIFT;
          start      = 1'b1;
          load_tx    = !CPHA;
        end
      end
      SHIFT: begin
        if (ssn_rise) begin
          state_next = IDLE;
        end else begin
          if (drive_edge) begin
            if (bit_cnt == '0 && !loaded) load_tx  = 1'b1;
            else                          shift_tx = 1'b1;
          end
          sample = sample_edge;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign word_done = sample && (bit_cnt == LAST_BIT);
  assign rx_next   = MSB_FIRST ? {rx_shreg[WORD_SIZE-2:0], mosi_sync[1]}
                               : {mosi_sync[1], rx_shreg[WORD_SIZE-1:1]};

  logic tx_empty, tx_full, tx_push, tx_pop;
  logic rx_full, rx_push, rx_pop, rx_drop;
  assign tx_empty = tx_cnt == '0;
  assign tx_full  = tx_cnt == TX_FULL;
  assign tx_push  = bus.tx_valid && !tx_full;
  assign tx_pop   = load_tx && !tx_empty;
  assign rx_full  = rx_cnt == RX_FULL;
  assign rx_pop   = bus.rx_ready && (rx_cnt != '0);
  assign rx_push  = word_done && (!rx_full || rx_pop);
  assign rx_drop  = word_done && rx_full && !rx_pop;

  always_ff @(posedge sys_clk) begin
    if (tx_push) tx_mem[tx_wr] <= bus.tx_data;
    if (rx_push) rx_mem[rx_wr] <= rx_next;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bit_cnt      <= '0;
      loaded       <= 1'b0;
      word_count   <= '0;
      tx_shreg     <= '0;
      rx_shreg     <= '0;
      tx_wr        <= '0;
      tx_rd        <= '0;
      tx_cnt       <= '0;
      rx_wr        <= '0;
      rx_rd        <= '0;
      rx_cnt       <= '0;
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      if (start) begin
        bit_cnt    <= '0;
        word_count <= '0;
      end else if (sample) begin
        bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
        if (word_done && word_count != 16'hFFFF) word_count <= word_count + 16'd1;
      end
      if (load_tx)                 loaded <= 1'b1;
      else if (start || word_done) loaded <= 1'b0;
      if (load_tx)       tx_shreg <= tx_empty ? IDLE_WORD : tx_mem[tx_rd];
      else if (shift_tx) tx_shreg <= MSB_FIRST ? (tx_shreg << 1) : (tx_shreg >> 1);
      if (sample) rx_shreg <= rx_next;
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
      // A set event in the same cycle as status_clr keeps the flag set
      rx_overflow  <= rx_drop | (rx_overflow & ~bus.status_clr);
      tx_underflow <= (load_tx & tx_empty) | (tx_underflow & ~bus.status_clr);
    end
  end

  assign bus.miso         = tx_shreg[OUT_BIT];
  assign bus.miso_oe      = state == SHIFT;
  assign bus.active       = state == SHIFT;
  assign bus.tx_ready     = !tx_full;
  assign bus.rx_valid     = rx_cnt != '0;
  assign bus.rx_data      = (rx_cnt != '0) ? rx_mem[rx_rd] : '0;
  assign bus.rx_overflow  = rx_overflow;
  assign bus.tx_underflow = tx_underflow;
  assign bus.word_count   = word_count;
endmodule

// File: tb/tb_spi_sub_oversampled.sv
// Scoreboard bench for spi_sub_oversampled: four instances cover the SPI modes;
// instance 0 (mode 0, MSB first, RX_DEPTH 4, IDLE_WORD FF) also covers flags, abort and reset.
module tb_spi_sub_oversampled;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sclk_base = 1'b0;
  logic       ssn_base  = 1'b1;
  logic       mosi      = 1'b0;
  logic       status_clr = 1'b0;
  logic [7:0] tx_data   = '0;
  logic [3:0] tx_valid  = '0;
  logic [3:0] rx_ready  = '0;
  int         sel       = 0;

  logic [3:0] miso_w, oe_w, act_w, txr_w, rxv_w, ovf_w, unf_w;
  logic [7:0]  rxd_w [4];
  logic [15:0] wc_w  [4];

  logic [7:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit         CPOL_G = (g >= 2);
    localparam bit         CPHA_G = (g == 1) || (g == 3);
    localparam bit         MSB_G  = (g == 0);
    localparam int         RXD_G  = (g == 0) ? 4 : 8;
    localparam logic [7:0] IDLE_G = (g == 0) ? 8'hFF : 8'h00;

    spi_sub_oversampled_if #(.WORD_SIZE(8)) bus ();

    assign bus.sclk       = sclk_base ^ CPOL_G;
    assign bus.ssn        = (sel == g) ? ssn_base : 1'b1;
    assign bus.mosi       = mosi;
    assign bus.tx_data    = tx_data;
    assign bus.tx_valid   = tx_valid[g];
    assign bus.rx_ready   = rx_ready[g];
    assign bus.status_clr = status_clr;
    assign miso_w[g] = bus.miso;
    assign oe_w[g]   = bus.miso_oe;
    assign act_w[g]  = bus.active;
    assign txr_w[g]  = bus.tx_ready;
    assign rxv_w[g]  = bus.rx_valid;
    assign ovf_w[g]  = bus.rx_overflow;
    assign unf_w[g]  = bus.tx_underflow;
    assign rxd_w[g]  = bus.rx_data;
    assign wc_w[g]   = bus.word_count;

    spi_sub_oversampled #(
      .WORD_SIZE(8), .RX_DEPTH(RXD_G), .TX_DEPTH(8), .CPOL(CPOL_G),
      .CPHA(CPHA_G), .MSB_FIRST(MSB_G), .IDLE_WORD(IDLE_G)
    ) dut (
      .sys_clk(clk),
      .sys_rst(rst),
      .bus(bus.slave)
    );
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted RX pop is compared against the front of the expected queue
  logic [7:0] exp_word;
  always begin
    @(negedge clk);
    #1;
    for (int g = 0; g < 4; g++) begin
      if (rxv_w[g] && rx_ready[g]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rx_pop_unexpected inst=%0d actual=%0h required=none", g, rxd_w[g]);
        end else begin
          exp_word = exp_q.pop_front();
          check_output("rx_data", {24'd0, rxd_w[g]}, {24'd0, exp_word});
        end
      end
    end
  end

  task automatic push_tx(input int s, input logic [7:0] d);
    @(negedge clk);
    tx_data     = d;
    tx_valid[s] = 1'b1;
    @(negedge clk);
    tx_valid[s] = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_xfer(input int s);
    @(negedge clk);
    sel      = s;
    ssn_base = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic end_xfer();
    repeat (HALF) @(negedge clk);
    ssn_base = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Clocks nbits of mo out on mosi and collects the bits seen on miso
  task automatic xfer_bits(input int s, input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    bit cpha, msb;
    int b;
    cpha = (s == 1) || (s == 3);
    msb  = (s == 0);
    mi   = '0;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? 7 - i : i;
      if (!cpha) begin
        mosi = mo[b];
        repeat (HALF) @(negedge clk);
        mi[b] = miso_w[s];
        sclk_base = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk_base = 1'b0;
      end else begin
        sclk_base = 1'b1;
        mosi      = mo[b];
        repeat (HALF) @(negedge clk);
        mi[b] = miso_w[s];
        sclk_base = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic apply_stimulus(input int s, input logic [7:0] mo, input logic [7:0] exp_mi, input bit store);
    logic [7:0] mi;
    if (store) exp_q.push_back(mo);
    xfer_bits(s, mo, 8, mi);
    check_output("miso_word", {24'd0, mi}, {24'd0, exp_mi});
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check_output("rx_drain_left", exp_q.size(), 0);
  endtask

  logic [7:0] dummy;

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      check_output("rst_miso", {31'd0, miso_w[g]}, 0);
      check_output("rst_miso_oe", {31'd0, oe_w[g]}, 0);
      check_output("rst_active", {31'd0, act_w[g]}, 0);
      check_output("rst_tx_ready", {31'd0, txr_w[g]}, 1);
      check_output("rst_rx_valid", {31'd0, rxv_w[g]}, 0);
      check_output("rst_rx_data", {24'd0, rxd_w[g]}, 0);
      check_output("rst_flags", {30'd0, ovf_w[g], unf_w[g]}, 0);
      check_output("rst_word_count", {16'd0, wc_w[g]}, 0);
    end

    // Mode 0 MSB first: two words each way
    rx_ready = 4'b1111;
    push_tx(0, 8'hA5);
    push_tx(0, 8'h3C);
    begin_xfer(0);
    check_output("m0_miso_oe", {31'd0, oe_w[0]}, 1);
    apply_stimulus(0, 8'h5A, 8'hA5, 1'b1);
    apply_stimulus(0, 8'hC3, 8'h3C, 1'b1);
    end_xfer();
    check_output("m0_word_count", {16'd0, wc_w[0]}, 2);
    check_output("m0_miso_oe_off", {31'd0, oe_w[0]}, 0);
    check_output("m0_underflow_after_tail_load", {31'd0, unf_w[0]}, 1);
    wait_drain();
    pulse_clr();
    check_output("m0_underflow_clr", {31'd0, unf_w[0]}, 0);

    // TX empty: IDLE_WORD goes out and underflow sticks until cleared
    begin_xfer(0);
    apply_stimulus(0, 8'h00, 8'hFF, 1'b1);
    apply_stimulus(0, 8'h11, 8'hFF, 1'b1);
    end_xfer();
    repeat (10) @(negedge clk);
    check_output("idle_underflow", {31'd0, unf_w[0]}, 1);
    pulse_clr();
    check_output("idle_underflow_clr", {31'd0, unf_w[0]}, 0);
    wait_drain();

    // RX overflow on the depth-4 instance
    rx_ready[0] = 1'b0;
    begin_xfer(0);
    for (int i = 1; i <= 5; i++) apply_stimulus(0, 8'(i), 8'hFF, i <= 4);
    end_xfer();
    check_output("ovf_flag", {31'd0, ovf_w[0]}, 1);
    check_output("ovf_word_count", {16'd0, wc_w[0]}, 5);
    check_output("ovf_rx_valid", {31'd0, rxv_w[0]}, 1);
    rx_ready[0] = 1'b1;
    wait_drain();
    @(negedge clk);
    check_output("ovf_rx_empty", {31'd0, rxv_w[0]}, 0);
    pulse_clr();
    check_output("ovf_flag_clr", {30'd0, ovf_w[0], unf_w[0]}, 0);

    // Aborted partial word followed by a clean 8'h77
    begin_xfer(0);
    xfer_bits(0, 8'hFF, 5, dummy);
    end_xfer();
    begin_xfer(0);
    apply_stimulus(0, 8'h77, 8'hFF, 1'b1);
    end_xfer();
    check_output("abort_word_count", {16'd0, wc_w[0]}, 1);
    wait_drain();
    pulse_clr();

    // Modes 1-3, LSB first
    for (int s = 1; s < 4; s++) begin
      push_tx(s, 8'h81);
      push_tx(s, 8'h35);
      begin_xfer(s);
      apply_stimulus(s, 8'h81, 8'h81, 1'b1);
      apply_stimulus(s, 8'hC8, 8'h35, 1'b1);
      end_xfer();
      check_output("mode_word_count", {16'd0, wc_w[s]}, 2);
      wait_drain();
    end

    // Reset pulse in the middle of a word
    rx_ready[0] = 1'b0;
    begin_xfer(0);
    apply_stimulus(0, 8'h44, 8'hFF, 1'b0);
    end_xfer();
    check_output("pre_rst_rx_valid", {31'd0, rxv_w[0]}, 1);
    push_tx(0, 8'h12);
    push_tx(0, 8'h34);
    begin_xfer(0);
    xfer_bits(0, 8'hAA, 3, dummy);
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_miso", {31'd0, miso_w[0]}, 0);
    check_output("mid_rst_oe_active", {30'd0, oe_w[0], act_w[0]}, 0);
    check_output("mid_rst_rx_valid", {31'd0, rxv_w[0]}, 0);
    check_output("mid_rst_rx_data", {24'd0, rxd_w[0]}, 0);
    check_output("mid_rst_flags", {30'd0, ovf_w[0], unf_w[0]}, 0);
    check_output("mid_rst_word_count", {16'd0, wc_w[0]}, 0);
    check_output("mid_rst_tx_ready", {31'd0, txr_w[0]}, 1);
    rst = 1'b0;
    @(negedge clk);
    xfer_bits(0, 8'hAA, 5, dummy);
    check_output("post_rst_ignored_active", {31'd0, act_w[0]}, 0);
    check_output("post_rst_ignored_word_count", {16'd0, wc_w[0]}, 0);
    end_xfer();
    rx_ready[0] = 1'b1;
    push_tx(0, 8'h96);
    begin_xfer(0);
    apply_stimulus(0, 8'h69, 8'h96, 1'b1);
    end_xfer();
    check_output("post_rst_word_count", {16'd0, wc_w[0]}, 1);
    wait_drain();

    repeat (20) @(negedge clk);
    check_output("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
